// File: rtl/data_mem_responder_if.sv
// Data-port bus between the CPU datapath and its data memory responder.
// Carries one request (read/write, address, store data) and a pulsed response.
// The requester holds the request until it sees ready; the responder samples it only while idle.
interface data_mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM that answers CPU load/store requests with a one-cycle ready pulse.
// Latency: request sampled in IDLE, ready high WAIT_CYCLES+1 cycles later.
// Backpressure: none downstream; requests are ignored while busy and the requester waits for ready.
module data_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Latched copy of the request; the live bus is ignored once a transaction starts.
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               rd_q;
    logic               wr_q;
    logic               err_q;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               req;
    logic               start;
    logic [ADDR_W-3:0]  widx;
    logic               req_err;

    assign widx  = bus.addr[ADDR_W-1:2];
    assign req   = bus.mem_read | bus.mem_write;
    assign start = (state_q == IDLE) && req;

    // A request is rejected when misaligned, beyond the RAM, or asking for both read and write.
    assign req_err = (bus.addr[1:0] != 2'b00)
                  || (widx >= (ADDR_W-2)'(DEPTH_WORDS))
                  || (bus.mem_read && bus.mem_write);

    // State register and wait counter; reset aborts any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request at the IDLE edge where it is first seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (start) begin
            idx_q   <= widx[IDX_W-1:0];
            wdata_q <= bus.wdata;
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            err_q   <= req_err;
        end
    end

    // Next-state: IDLE -> BUSY (counting wait states) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response outputs are only non-zero during the single DONE cycle.
    always_comb begin
        bus.ready = 1'b0;
        bus.err   = 1'b0;
        bus.rdata = '0;
        if (state_q == DONE) begin
            bus.ready = 1'b1;
            bus.err   = err_q;
            if (rd_q && !err_q) begin
                bus.rdata = mem_q[idx_q];
            end
        end
    end

    // Store commits at the end of DONE so a following load already sees it; reset drops it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == DONE) && wr_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
endmodule
